traffic_phase_ctrl: RTL and testbench
=====================================

# traffic_phase_ctrl

N-approach intersection controller generalising the two-way NS/EW light. It owns its own tick prescaler and cycles green, yellow and all-red phases round-robin over approaches that have demand. A level emergency input pre-empts the cycle in favour of a selected approach. The block sits between the board clock/reset and the lamp drivers, and replaces the fixed two-direction controller.

## Interface
- N_APPROACH, 4: number of approaches, 2..8
- CLK_DIV, 100000000: clk cycles per timing tick
- GREEN_T, 5: green duration in ticks, ≥1
- YELLOW_T, 2: yellow duration in ticks, ≥1
- ALLRED_T, 1: all-red clearance in ticks, ≥1
- AW, $clog2(N_APPROACH): approach index width
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- emergency  in  1  level pre-emption request
- emg_dir  in  AW  approach to serve during emergency
- demand  in  N_APPROACH  per-approach vehicle demand
- green  out  N_APPROACH  green lamps, registered
- yellow  out  N_APPROACH  yellow lamps, registered
- red  out  N_APPROACH  red lamps, registered
- phase  out  AW  approach currently owning right-of-way
- emg_active  out  1  high in any emergency-path state

## Operation
- Six states:
  - ALLRED: all approaches red.
  - GREEN: `phase` is green, others red.
  - YELLOW: `phase` is yellow, others red.
  - EMG_YEL: the displaced approach is yellow.
  - EMG_RED: all-red before the emergency green.
  - EMG_HOLD: `emg_dir` is green.
- Lamp invariant: each approach has exactly one of green/yellow/red set, every cycle.
- Reset values: state=ALLRED, phase=0, green=0, yellow=0, red=all ones, emg_active=0. The prescaler and timer are cleared.
- Normal cycle: ALLRED → GREEN(next) → YELLOW → ALLRED → …
- Next-approach selection: the first index with a demand bit set, searching phase+1 … phase+N_APPROACH modulo N. The current approach is checked last.
  - If demand is all zero, the next approach is phase+1 mod N, giving a fixed rotation.
  - Selection is evaluated on the ALLRED→GREEN transition.
  - The first GREEN after reset always goes to approach 0.
- Emergency, sampled every clk:
  - In GREEN with emg_dir≠phase: go to EMG_YEL on the next clk, then EMG_RED, then EMG_HOLD. `phase` becomes emg_dir on entry to EMG_HOLD.
  - In GREEN with emg_dir==phase: go straight to EMG_HOLD, with no lamp change.
  - In YELLOW or ALLRED: finish that state, then follow the EMG_RED → EMG_HOLD path. If the emergency arrives during ALLRED, that ALLRED counts as the clearance and EMG_HOLD follows directly.
  - emg_dir is latched on emergency assertion. Changes while emergency stays high are ignored.
  - In EMG_HOLD, emergency low → YELLOW(phase) → ALLRED → normal selection from the emergency approach.
  - Emergency dropping before EMG_HOLD is reached: complete the clearance, then enter normal ALLRED.
- emg_active=1 in EMG_YEL, EMG_RED and EMG_HOLD, and in the YELLOW that follows EMG_HOLD.

## Timing
- Tick: the prescaler asserts for one clk every CLK_DIV cycles. It restarts at 0 on every state entry.
- State duration: each timed state lasts exactly T×CLK_DIV clk cycles.
  - GREEN uses GREEN_T; YELLOW and EMG_YEL use YELLOW_T; ALLRED and EMG_RED use ALLRED_T.
- Timer: loaded with T−1 on entry, decremented on tick. The state exits on a tick with timer==0.
- EMG_HOLD is untimed.
- Outputs are registered: lamps change on the clk edge where the state register changes. There is no combinational path from inputs to lamps.
- Emergency pre-emption of GREEN: yellow appears 1 clk after emergency is first sampled high.
- Reset mid-operation: the next clk shows reset values, regardless of state or emergency.

## Structure
- traffic_pkg holds:
  - the state encoding constants;
  - the next_approach(phase, demand) function, a rotating priority search;
  - the lamp encoding helper.
- Sub-module tick_prescaler (parameter CLK_DIV; ports clk, reset, restart, tick).
- The remaining FSM, timer and lamp registers live in traffic_phase_ctrl.

## Test plan
All scenarios use N_APPROACH=4, CLK_DIV=4, GREEN_T=5, YELLOW_T=2, ALLRED_T=1.
- Reset, then demand=4'b1111:
  - red=4'b1111 and green=0 while reset is high.
  - After release: 4 clk all-red, then green[0] for 20 clk, yellow[0] for 8, all-red for 4, then green[1].
- demand=4'b1001 → greens alternate 0,3,0,3. Approaches 1 and 2 are never green.
- demand=4'b0000 → greens rotate 0,1,2,3,0, with the same durations.
- emergency=1, emg_dir=2, raised at green[0] cycle 6:
  - yellow[0] next clk for 8 clk, all-red 4 clk, then green[2] held indefinitely with emg_active=1.
  - Drop emergency → yellow[2] 8 clk, all-red 4, then green[3].
- emergency=1 with emg_dir=phase during GREEN → green held past 20 clk. Drop it → YELLOW on the same approach.
- Reset pulsed during yellow[1] → next clk red=4'b1111, phase=0. The cycle then restarts at all-red.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and helpers for the N-approach traffic phase controller:
// FSM state encoding, rotating-priority approach search and per-approach lamp encoding.
package traffic_pkg;

   localparam int unsigned MAX_APPROACH = 8;

   typedef enum logic [2:0] {
      ST_ALLRED,
      ST_GREEN,
      ST_YELLOW,
      ST_EMG_YEL,
      ST_EMG_RED,
      ST_EMG_HOLD
   } state_t;

   typedef struct packed {
      logic g;
      logic y;
      logic r;
   } lamp_t;

   // First demanding approach after phase (phase itself last); plain rotation when idle.
   function automatic int unsigned next_approach(input int unsigned phase,
                                                 input int unsigned demand,
                                                 input int unsigned n);
      int unsigned sel;
      int unsigned idx;
      logic        found;
      sel   = (phase + 1) % n;
      found = 1'b0;
      for (int unsigned k = 1; k <= MAX_APPROACH; k++) begin
         idx = (phase + k) % n;
         if (k <= n && !found && (((demand >> idx) & 32'd1) != 32'd0)) begin
            sel   = idx;
            found = 1'b1;
         end
      end
      return sel;
   endfunction

   function automatic lamp_t lamp_encode(input state_t st, input logic owner);
      lamp_t l;
      l = '{g: 1'b0, y: 1'b0, r: 1'b1};
      if (owner) begin
         case (st)
            ST_GREEN, ST_EMG_HOLD: l = '{g: 1'b1, y: 1'b0, r: 1'b0};
            ST_YELLOW, ST_EMG_YEL: l = '{g: 1'b0, y: 1'b1, r: 1'b0};
            default:               l = '{g: 1'b0, y: 1'b0, r: 1'b1};
         endcase
      end
      return l;
   endfunction

endpackage

// File: rtl/traffic_phase_ctrl_tick_prescaler.sv
// Free-running clk divider producing a one-cycle tick every CLK_DIV cycles;
// restart re-aligns the count so every state starts on a fresh tick period.
module tick_prescaler #(
   parameter int unsigned CLK_DIV = 100000000
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic tick
);

   localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] count;

   assign tick = (count == CW'(CLK_DIV - 1));

   always_ff @(posedge clk) begin
      if (reset || restart || tick) count <= '0;
      else                          count <= count + 1'b1;
   end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-approach round-robin traffic light controller with emergency pre-emption;
// all lamp/phase outputs are registered from the next-state decode.
module traffic_phase_ctrl
   import traffic_pkg::*;
#(
   parameter int unsigned N_APPROACH = 4,
   parameter int unsigned CLK_DIV    = 100000000,
   parameter int unsigned GREEN_T    = 5,
   parameter int unsigned YELLOW_T   = 2,
   parameter int unsigned ALLRED_T   = 1,
   parameter int unsigned AW         = $clog2(N_APPROACH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  emergency,
   input  logic [AW-1:0]         emg_dir,
   input  logic [N_APPROACH-1:0] demand,
   output logic [N_APPROACH-1:0] green,
   output logic [N_APPROACH-1:0] yellow,
   output logic [N_APPROACH-1:0] red,
   output logic [AW-1:0]         phase,
   output logic                  emg_active
);

   localparam int unsigned TMAX = (GREEN_T > YELLOW_T) ?
                                  ((GREEN_T > ALLRED_T) ? GREEN_T : ALLRED_T) :
                                  ((YELLOW_T > ALLRED_T) ? YELLOW_T : ALLRED_T);
   localparam int unsigned TW = $clog2(TMAX + 1);

   typedef logic [TW-1:0] tmr_t;

   state_t                  state, state_nx;
   logic [AW-1:0]           phase_nx, edir_q, edir_eff;
   logic                    emg_q, first_q, first_nx, eyel_q, eyel_nx;
   tmr_t                    timer;
   logic                    tick, restart, done, emg_nx;
   logic [N_APPROACH-1:0]   green_nx, yellow_nx, red_nx;
   lamp_t                   lamp;

   function automatic tmr_t dur(input state_t s);
      case (s)
         ST_GREEN:              return tmr_t'(GREEN_T - 1);
         ST_YELLOW, ST_EMG_YEL: return tmr_t'(YELLOW_T - 1);
         default:               return tmr_t'(ALLRED_T - 1);
      endcase
   endfunction

   tick_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
      .clk     (clk),
      .reset   (reset),
      .restart (restart),
      .tick    (tick)
   );

   assign done     = tick && (timer == '0);
   assign restart  = (state_nx != state);
   // A direction presented on the rising edge of emergency is usable in that same cycle.
   assign edir_eff = (emergency && !emg_q) ? emg_dir : edir_q;

   always_comb begin
      state_nx = state;
      phase_nx = phase;
      first_nx = first_q;
      eyel_nx  = eyel_q;
      case (state)
         ST_ALLRED: if (done) begin
            first_nx = 1'b0;
            if (emergency) begin
               state_nx = ST_EMG_HOLD;
               phase_nx = edir_eff;
            end else begin
               state_nx = ST_GREEN;
               phase_nx = first_q ? '0 :
                          AW'(next_approach(32'(phase), 32'(demand), N_APPROACH));
            end
         end
         ST_GREEN: begin
            if (emergency) begin
               state_nx = (edir_eff == phase) ? ST_EMG_HOLD : ST_EMG_YEL;
            end else if (done) begin
               state_nx = ST_YELLOW;
               eyel_nx  = 1'b0;
            end
         end
         ST_YELLOW, ST_EMG_YEL: if (done) begin
            state_nx = emergency ? ST_EMG_RED : ST_ALLRED;
         end
         ST_EMG_RED: if (done) begin
            if (emergency) begin
               state_nx = ST_EMG_HOLD;
               phase_nx = edir_eff;
            end else begin
               state_nx = ST_ALLRED;
            end
         end
         ST_EMG_HOLD: if (!emergency) begin
            state_nx = ST_YELLOW;
            eyel_nx  = 1'b1;
         end
         default: state_nx = ST_ALLRED;
      endcase
   end

   always_comb begin
      green_nx  = '0;
      yellow_nx = '0;
      red_nx    = '1;
      lamp      = '{g: 1'b0, y: 1'b0, r: 1'b1};
      for (int unsigned i = 0; i < N_APPROACH; i++) begin
         lamp         = lamp_encode(state_nx, phase_nx == AW'(i));
         green_nx[i]  = lamp.g;
         yellow_nx[i] = lamp.y;
         red_nx[i]    = lamp.r;
      end
      emg_nx = (state_nx inside {ST_EMG_YEL, ST_EMG_RED, ST_EMG_HOLD}) ||
               (state_nx == ST_YELLOW && eyel_nx);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_ALLRED;
         phase      <= '0;
         timer      <= tmr_t'(ALLRED_T - 1);
         edir_q     <= '0;
         emg_q      <= 1'b0;
         first_q    <= 1'b1;
         eyel_q     <= 1'b0;
         green      <= '0;
         yellow     <= '0;
         red        <= '1;
         emg_active <= 1'b0;
      end else begin
         state      <= state_nx;
         phase      <= phase_nx;
         first_q    <= first_nx;
         eyel_q     <= eyel_nx;
         emg_q      <= emergency;
         if (emergency && !emg_q) edir_q <= emg_dir;
         if (restart)                    timer <= dur(state_nx);
         else if (tick && timer != '0)   timer <= timer - 1'b1;
         green      <= green_nx;
         yellow     <= yellow_nx;
         red        <= red_nx;
         emg_active <= emg_nx;
      end
   end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl: phase-run tables, emergency/reset sequences
// and randomized traffic compared against a cycle-countdown reference model.
module tb_traffic_phase_ctrl;

   localparam int N   = 4;
   localparam int DIV = 4;
   localparam int GT  = 5;
   localparam int YT  = 2;
   localparam int RT  = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       emg = 1'b0;
   logic [1:0] edir = '0;
   logic [3:0] dem = '0;
   logic [3:0] green, yellow, red;
   logic [1:0] phase;
   logic       emg_active;

   int checks = 0;
   int errors = 0;

   traffic_phase_ctrl #(
      .N_APPROACH (N),
      .CLK_DIV    (DIV),
      .GREEN_T    (GT),
      .YELLOW_T   (YT),
      .ALLRED_T   (RT)
   ) dut (
      .clk        (clk),
      .reset      (rst),
      .emergency  (emg),
      .emg_dir    (edir),
      .demand     (dem),
      .green      (green),
      .yellow     (yellow),
      .red        (red),
      .phase      (phase),
      .emg_active (emg_active)
   );

   always #5 clk = ~clk;

   // Reference model: each mode simply lasts a number of clk cycles.
   typedef enum int {M_ALLRED, M_GREEN, M_YELLOW, M_EYEL, M_ERED, M_EHOLD} mode_t;
   mode_t m_mode;
   int    m_left, m_phase, m_edir;
   bit    m_first, m_prev, m_eyel;
   bit [3:0] m_g, m_y, m_r;
   bit    m_emg;

   function automatic int pick(input int p, input bit [3:0] d);
      for (int k = 1; k <= N; k++) begin
         int a;
         a = (p + k) % N;
         if (d[a]) return a;
      end
      return (p + 1) % N;
   endfunction

   function automatic int mode_cycles(input mode_t m);
      case (m)
         M_GREEN:          return GT * DIV;
         M_YELLOW, M_EYEL: return YT * DIV;
         M_EHOLD:          return 1 << 30;
         default:          return RT * DIV;
      endcase
   endfunction

   task automatic model_step();
      mode_t nx;
      int    dir, nph;
      bit    leave;
      if (rst) begin
         m_mode = M_ALLRED; m_left = mode_cycles(M_ALLRED); m_phase = 0; m_edir = 0;
         m_first = 1; m_prev = 0; m_eyel = 0;
      end else begin
         dir = (emg && !m_prev) ? int'(edir) : m_edir;
         if (emg && !m_prev) m_edir = int'(edir);
         m_prev = emg;
         m_left--;
         leave = (m_left == 0);
         nx = m_mode; nph = m_phase;
         case (m_mode)
            M_ALLRED: if (leave) begin
               if (emg) begin nx = M_EHOLD; nph = dir; end
               else begin nx = M_GREEN; nph = m_first ? 0 : pick(m_phase, dem); end
               m_first = 0;
            end
            M_GREEN: if (emg) nx = (dir == m_phase) ? M_EHOLD : M_EYEL;
                     else if (leave) begin nx = M_YELLOW; m_eyel = 0; end
            M_YELLOW, M_EYEL: if (leave) nx = emg ? M_ERED : M_ALLRED;
            M_ERED: if (leave) begin
               if (emg) begin nx = M_EHOLD; nph = dir; end
               else nx = M_ALLRED;
            end
            M_EHOLD: if (!emg) begin nx = M_YELLOW; m_eyel = 1; end
            default: nx = M_ALLRED;
         endcase
         if (nx != m_mode) m_left = mode_cycles(nx);
         m_mode = nx; m_phase = nph;
      end
      m_g = '0; m_y = '0;
      if (m_mode == M_GREEN || m_mode == M_EHOLD) m_g[m_phase] = 1'b1;
      if (m_mode == M_YELLOW || m_mode == M_EYEL) m_y[m_phase] = 1'b1;
      m_r = ~(m_g | m_y);
      m_emg = (m_mode inside {M_EYEL, M_ERED, M_EHOLD}) || (m_mode == M_YELLOW && m_eyel);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clk: model advances on the edge, DUT sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      chk("model", {17'd0, green, yellow, red, phase, emg_active},
          {17'd0, m_g, m_y, m_r, m_phase[1:0], m_emg});
      chk("one_lamp", {28'd0, (green ^ yellow ^ red) & ~(green & yellow) & ~(green & red)
                               & ~(yellow & red)}, 32'hF);
   endtask

   task automatic expect_lamps(input byte kind, input int idx, input int n, input bit exp_emg);
      logic [3:0] g, y;
      g = '0; y = '0;
      if (kind == "G") g[idx] = 1'b1;
      if (kind == "Y") y[idx] = 1'b1;
      for (int i = 0; i < n; i++) begin
         step();
         chk("lamps", {20'd0, green, yellow, red}, {20'd0, g, y, ~(g | y)});
         chk("emg_active", {31'd0, emg_active}, {31'd0, exp_emg});
      end
   endtask

   task automatic do_reset(input logic [3:0] d);
      dem = d; emg = 1'b0; rst = 1'b1;
      step();
      chk("reset_red", {28'd0, red}, 32'hF);
      chk("reset_green", {28'd0, green}, 32'h0);
      step();
      chk("reset_phase", {30'd0, phase}, 32'h0);
      chk("reset_emg", {31'd0, emg_active}, 32'h0);
      rst = 1'b0;
   endtask

   typedef struct {
      bit       rst_first;
      bit [3:0] demand;
      byte      kind;
      int       idx;
      int       cycles;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input bit r, input bit [3:0] d, input byte k, input int i, input int c);
      vec_t v;
      v.rst_first = r; v.demand = d; v.kind = k; v.idx = i; v.cycles = c;
      tbl.push_back(v);
   endtask

   initial begin
      // demand 1111: reset run, then approach 0 then 1
      add(1, 4'b1111, "R", 0, 4);
      add(0, 4'b1111, "G", 0, 20); add(0, 4'b1111, "Y", 0, 8); add(0, 4'b1111, "R", 0, 4);
      add(0, 4'b1111, "G", 1, 20);
      // demand 1001: alternate 0 and 3
      add(1, 4'b1001, "R", 0, 4);
      for (int r = 0; r < 2; r++) begin
         add(0, 4'b1001, "G", 0, 20); add(0, 4'b1001, "Y", 0, 8); add(0, 4'b1001, "R", 0, 4);
         add(0, 4'b1001, "G", 3, 20); add(0, 4'b1001, "Y", 3, 8); add(0, 4'b1001, "R", 0, 4);
      end
      // demand 0000: fixed rotation 0,1,2,3,0
      add(1, 4'b0000, "R", 0, 4);
      for (int a = 0; a < 4; a++) begin
         add(0, 4'b0000, "G", a, 20); add(0, 4'b0000, "Y", a, 8); add(0, 4'b0000, "R", 0, 4);
      end
      add(0, 4'b0000, "G", 0, 5);

      foreach (tbl[i]) begin
         if (tbl[i].rst_first) begin
            do_reset(tbl[i].demand);
            chk("reset_allred", {28'd0, red}, 32'hF);
            expect_lamps(tbl[i].kind, tbl[i].idx, tbl[i].cycles - 1, 1'b0);
         end else begin
            dem = tbl[i].demand;
            expect_lamps(tbl[i].kind, tbl[i].idx, tbl[i].cycles, 1'b0);
         end
      end

      // Emergency to approach 2 raised at green[0] cycle 6; dir changes while held are ignored.
      do_reset(4'b1111);
      expect_lamps("R", 0, 3, 1'b0);
      expect_lamps("G", 0, 6, 1'b0);
      emg = 1'b1; edir = 2'd2;
      expect_lamps("Y", 0, 8, 1'b1);
      expect_lamps("R", 0, 4, 1'b1);
      expect_lamps("G", 2, 10, 1'b1);
      edir = 2'd1;
      expect_lamps("G", 2, 30, 1'b1);
      chk("emg_phase", {30'd0, phase}, 32'd2);
      emg = 1'b0;
      expect_lamps("Y", 2, 8, 1'b1);
      expect_lamps("R", 0, 4, 1'b0);
      expect_lamps("G", 3, 2, 1'b0);

      // Emergency for the approach already green: held, then yellow on the same approach.
      do_reset(4'b1111);
      expect_lamps("R", 0, 3, 1'b0);
      expect_lamps("G", 0, 3, 1'b0);
      emg = 1'b1; edir = 2'd0;
      expect_lamps("G", 0, 40, 1'b1);
      emg = 1'b0;
      expect_lamps("Y", 0, 8, 1'b1);
      expect_lamps("R", 0, 4, 1'b0);
      expect_lamps("G", 1, 1, 1'b0);

      // Reset pulsed during yellow[1].
      do_reset(4'b1111);
      expect_lamps("R", 0, 3, 1'b0);
      expect_lamps("G", 0, 20, 1'b0); expect_lamps("Y", 0, 8, 1'b0);
      expect_lamps("R", 0, 4, 1'b0);  expect_lamps("G", 1, 20, 1'b0);
      expect_lamps("Y", 1, 3, 1'b0);
      rst = 1'b1;
      step();
      chk("midrst_red", {28'd0, red}, 32'hF);
      chk("midrst_phase", {30'd0, phase}, 32'd0);
      rst = 1'b0;
      expect_lamps("R", 0, 3, 1'b0);
      expect_lamps("G", 0, 2, 1'b0);

      // Randomized traffic, emergencies and occasional resets against the model.
      do_reset(4'($urandom));
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 19) == 0) dem = 4'($urandom);
         if ($urandom_range(0, 59) == 0) emg = ~emg;
         edir = 2'($urandom);
         rst  = ($urandom_range(0, 699) == 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
